// File: rtl/regfile_pkg.sv
// Shared constants and dump-sequencer state type for the architectural register file.
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;
endpackage

// File: rtl/register_dump_seq.sv
// Debug-dump sequencer: walks dbg_idx over every register, one beat per accepted handshake.
module register_dump_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    input  logic              dbg_ready,
    input  logic [DATA_W-1:0] sel_data,
    output logic [ADDR_W-1:0] dbg_idx,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_valid,
    output logic              dump_busy,
    output logic              dump_done
);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    dump_state_t       state, state_nxt;
    logic [ADDR_W-1:0] idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dbg_idx <= '0;
        end else begin
            state   <= state_nxt;
            dbg_idx <= idx_nxt;
        end
    end

    // dbg_idx only moves on an accepted beat and saturates at the last register.
    always_comb begin
        state_nxt = state;
        idx_nxt   = dbg_idx;
        case (state)
            IDLE: if (dump_start) begin
                state_nxt = SEND;
                idx_nxt   = '0;
            end
            SEND: if (dbg_ready) begin
                if (dbg_idx == LAST_IDX) state_nxt = DONE;
                else                     idx_nxt   = dbg_idx + 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dbg_valid = (state == SEND);
        dump_busy = (state == SEND) || (state == DONE);
        dump_done = (state == DONE);
        dbg_data  = sel_data;
    end
endmodule

// File: rtl/register_file32.sv
// 32x32 architectural register file: r0 hardwired to zero, two combinational reads, one write, debug dump.
module register_file32
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dbg_valid,
    input  logic              dbg_ready,
    output logic [ADDR_W-1:0] dbg_idx,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dump_done
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic                         wr_live;

    assign wr_live = we && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Forwarding lets an ALU operand see the result being written in the same cycle.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        if (ra == '0)                             return '0;
        else if (BYPASS && wr_live && ra == wr_addr) return wr_data;
        else                                      return regs[ra];
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
    end

    register_dump_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dump (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_start (dump_start),
        .dbg_ready  (dbg_ready),
        .sel_data   (regs[dbg_idx]),
        .dbg_idx    (dbg_idx),
        .dbg_data   (dbg_data),
        .dbg_valid  (dbg_valid),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );
endmodule

// File: tb/tb_register_file32.sv
// Bench for register_file32: read/write vector table on bypassed and non-bypassed instances, plus dump sequences.
module tb_register_file32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  wr_addr, rd_addr1, rd_addr2;
    logic [31:0] wr_data;
    logic        dump_start, dbg_ready;

    logic [31:0] rd_data1, rd_data2, dbg_data;
    logic        dump_busy, dbg_valid, dump_done;
    logic [4:0]  dbg_idx;

    logic [31:0] nb_rd1, nb_rd2, nb_dbg_data;
    logic        nb_busy, nb_valid, nb_done;
    logic [4:0]  nb_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    register_file32 #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .dump_start(dump_start), .dump_busy(dump_busy), .dbg_valid(dbg_valid),
        .dbg_ready(dbg_ready), .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dump_done(dump_done)
    );

    register_file32 #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(nb_rd1), .rd_addr2(rd_addr2), .rd_data2(nb_rd2),
        .dump_start(dump_start), .dump_busy(nb_busy), .dbg_valid(nb_valid),
        .dbg_ready(dbg_ready), .dbg_idx(nb_idx), .dbg_data(nb_dbg_data), .dump_done(nb_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        we = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1, ra2;
        logic [31:0] e1, e2;   // bypassed instance
        logic [31:0] n1, n2;   // non-bypassed instance
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] model[32];
    int          exp_idx, dones, cycles;

    initial begin
        vecs[0] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
        vecs[1] = '{1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd0,  32'hA5A5_A5A5, 32'h0,         32'h0,         32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[3] = '{1'b1, 5'd3,  32'h1234_5678, 5'd3,  5'd7,  32'h1234_5678, 32'hA5A5_A5A5, 32'h0,         32'hA5A5_A5A5};
        vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd3,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        vecs[5] = '{1'b1, 5'd3,  32'hDEAD_BEEF, 5'd0,  5'd3,  32'h0,         32'hDEAD_BEEF, 32'h0,         32'h1234_5678};
        vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd0,  32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0};
        vecs[7] = '{1'b1, 5'd31, 32'h8000_0001, 5'd30, 5'd31, 32'h0,         32'h8000_0001, 32'h0,         32'h0};
        vecs[8] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd7,  32'h8000_0001, 32'hA5A5_A5A5, 32'h8000_0001, 32'hA5A5_A5A5};

        rst_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0; dump_start = 1'b0; dbg_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_busy",  {31'b0, dump_busy}, 32'h0);
        chk("rst_valid", {31'b0, dbg_valid}, 32'h0);
        chk("rst_done",  {31'b0, dump_done}, 32'h0);
        chk("rst_idx",   {27'b0, dbg_idx},   32'h0);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
            #1;
            chk("rst_rd1", rd_data1, 32'h0);
            chk("rst_rd2", rd_data2, 32'h0);
        end

        // Read/write/bypass table
        for (int v = 0; v < 9; v++) begin
            we = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
            rd_addr1 = vecs[v].ra1; rd_addr2 = vecs[v].ra2;
            #1;
            chk($sformatf("v%0d_rd1", v),    rd_data1, vecs[v].e1);
            chk($sformatf("v%0d_rd2", v),    rd_data2, vecs[v].e2);
            chk($sformatf("v%0d_nb_rd1", v), nb_rd1,   vecs[v].n1);
            chk($sformatf("v%0d_nb_rd2", v), nb_rd2,   vecs[v].n2);
            cyc();
        end
        we = 1'b0;

        // Full dump with dbg_ready held high
        for (int n = 0; n < 32; n++) model[n] = 32'(n) * 32'h0101_0101;
        for (int n = 1; n < 32; n++) wr(5'(n), model[n]);
        dbg_ready = 1'b1;
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            chk($sformatf("d1_valid%0d", b), {31'b0, dbg_valid}, 32'h1);
            chk($sformatf("d1_idx%0d", b),   {27'b0, dbg_idx},   32'(b));
            chk($sformatf("d1_data%0d", b),  dbg_data,           model[b]);
            chk($sformatf("d1_done%0d", b),  {31'b0, dump_done}, 32'h0);
            cyc();
        end
        chk("d1_done_pulse", {31'b0, dump_done}, 32'h1);
        chk("d1_done_busy",  {31'b0, dump_busy}, 32'h1);
        chk("d1_done_valid", {31'b0, dbg_valid}, 32'h0);
        cyc();
        chk("d1_done_end", {31'b0, dump_done}, 32'h0);
        chk("d1_idle",     {31'b0, dump_busy}, 32'h0);

        // Stalling consumer, restart pulse mid-dump, write ahead of the beat
        exp_idx = 0; dones = 0; cycles = 0;
        dbg_ready = 1'b0;
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        while ((dump_busy || cycles == 0) && cycles < 200) begin
            dbg_ready  = cycles[0];
            dump_start = (cycles == 10);
            if (cycles == 6) begin
                we = 1'b1; wr_addr = 5'd20; wr_data = 32'hCAFE_F00D;
                model[20] = 32'hCAFE_F00D;
            end else begin
                we = 1'b0;
            end
            #1;
            if (dump_done) dones++;
            if (dbg_valid && dbg_ready) begin
                chk($sformatf("d2_idx%0d", exp_idx), {27'b0, dbg_idx}, 32'(exp_idx));
                chk($sformatf("d2_data%0d", exp_idx), dbg_data, model[exp_idx[4:0]]);
                exp_idx++;
            end
            cyc();
            cycles++;
        end
        we = 1'b0; dump_start = 1'b0;
        chk("d2_timeout", {31'b0, (cycles >= 200)}, 32'h0);
        chk("d2_beats",   32'(exp_idx), 32'd32);
        chk("d2_dones",   32'(dones),   32'd1);
        chk("d2_idle",    {31'b0, dump_busy}, 32'h0);

        // Reset at beat 10
        dbg_ready = 1'b1;
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        repeat (10) cyc();
        chk("d3_idx10", {27'b0, dbg_idx}, 32'd10);
        rst_n = 1'b0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd31;
        #1;
        chk("d3_rst_busy",  {31'b0, dump_busy}, 32'h0);
        chk("d3_rst_valid", {31'b0, dbg_valid}, 32'h0);
        chk("d3_rst_done",  {31'b0, dump_done}, 32'h0);
        chk("d3_rst_idx",   {27'b0, dbg_idx},   32'h0);
        chk("d3_rst_r5",    rd_data1, 32'h0);
        chk("d3_rst_r31",   rd_data2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            cyc();
            if (dump_done || dump_busy) dones++;
        end
        chk("d3_no_done", 32'(dones), 32'd0);
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        chk("d3_restart_valid", {31'b0, dbg_valid}, 32'h1);
        chk("d3_restart_idx",   {27'b0, dbg_idx},   32'h0);
        cyc();
        chk("d3_restart_idx1",  {27'b0, dbg_idx},   32'h1);
        chk("d3_restart_data1", dbg_data,           32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
